// File: rtl/dsp_overpack_pkg.sv
// Shared definitions for the over-packed DSP multiply-accumulate block.
// Holds default geometry, FSM states and accumulator width sizing.
package dsp_overpack_pkg;

    localparam int DEF_ACT_W   = 4;
    localparam int DEF_WGT_W   = 4;
    localparam int DEF_N_ACT   = 3;
    localparam int DEF_N_WGT   = 2;
    localparam int DEF_LANE_SP = 8;
    localparam int DEF_MAX_LEN = 256;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // One guard bit above the worst-case growth of MAX_LEN summed products.
    function automatic int acc_w(input int pw, input int max_len);
        return pw + $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/overpack_extract.sv
// Splits the packed product into signed per-lane products.
// Each field is corrected for the borrow left by the negative lanes below it.
module overpack_extract
    import dsp_overpack_pkg::*;
#(
    parameter int LANES   = DEF_N_ACT * DEF_N_WGT,
    parameter int LANE_SP = DEF_LANE_SP,
    parameter int PW      = DEF_ACT_W + DEF_WGT_W,
    parameter int P_W     = LANES * LANE_SP
) (
    input  logic [P_W-1:0]            p,
    output logic [LANES-1:0][PW-1:0]  lane
);

    assign lane[0] = p[0 +: PW];

    // The bit just below a field is the sign of the sum of all lower lanes.
    for (genvar k = 1; k < LANES; k++) begin : g_lane
        assign lane[k] = p[k*LANE_SP +: PW] + {{(PW-1){1'b0}}, p[k*LANE_SP-1]};
    end

endmodule

// File: rtl/dsp_overpack_mac.sv
// Packs N_ACT activations and N_WGT weights into one wide multiply per beat
// and accumulates every activation x weight product across a vector.
module dsp_overpack_mac
    import dsp_overpack_pkg::*;
#(
    parameter int ACT_W   = DEF_ACT_W,
    parameter int WGT_W   = DEF_WGT_W,
    parameter int N_ACT   = DEF_N_ACT,
    parameter int N_WGT   = DEF_N_WGT,
    parameter int LANE_SP = DEF_LANE_SP,
    parameter int MAX_LEN = DEF_MAX_LEN,
    localparam int PW     = ACT_W + WGT_W,
    localparam int ACC_W  = acc_w(ACT_W + WGT_W, MAX_LEN),
    localparam int LANES  = N_ACT * N_WGT
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [N_ACT*ACT_W-1:0]   in_act,
    input  logic [N_WGT*WGT_W-1:0]   in_wgt,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic [LANES*ACC_W-1:0]   out_acc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_ovf
);

    localparam int P_W    = LANES * LANE_SP;
    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int STAGES = 3;

    state_t                     state_q, state_d;
    logic                       accept, hs;
    logic [STAGES:0]            vld_pipe, last_pipe;
    logic [P_W-1:0]             b_pk, b_r, a_pk, p_r;
    logic [N_WGT*WGT_W-1:0]     w_r;
    logic [LANES-1:0][PW-1:0]   lane_c, lane_r;
    logic [LANES-1:0][ACC_W-1:0] acc;
    logic [CNT_W-1:0]           cnt;
    logic                       ovf;

    assign accept    = in_valid && RSTN && (state_q == ST_ACCUM);
    assign in_ready  = RSTN && (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign hs        = out_valid && out_ready;
    assign out_acc   = acc;
    assign out_ovf   = ovf;

    // Activations sit LANE_SP apart with zero fill so the multiplier sees them unsigned.
    always_comb begin
        b_pk = '0;
        for (int i = 0; i < N_ACT; i++)
            b_pk[i*LANE_SP +: ACT_W] = in_act[i*ACT_W +: ACT_W];
    end

    // Pre-adder: sign-extended weights land one activation group apart.
    always_comb begin
        a_pk = '0;
        for (int j = 0; j < N_WGT; j++)
            a_pk = a_pk + ({{(P_W-WGT_W){w_r[j*WGT_W+WGT_W-1]}}, w_r[j*WGT_W +: WGT_W]}
                           << (j*N_ACT*LANE_SP));
    end

    overpack_extract #(
        .LANES   (LANES),
        .LANE_SP (LANE_SP),
        .PW      (PW),
        .P_W     (P_W)
    ) u_extract (
        .p    (p_r),
        .lane (lane_c)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            b_r       <= '0;
            w_r       <= '0;
            p_r       <= '0;
            lane_r    <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
            last_pipe <= {last_pipe[STAGES-1:0], accept && in_last};
            b_r       <= b_pk;
            w_r       <= in_wgt;
            p_r       <= a_pk * b_r;
            lane_r    <= lane_c;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc <= '0;
        end else if (hs) begin
            acc <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            for (int k = 0; k < LANES; k++)
                acc[k] <= acc[k] + {{(ACC_W-PW){lane_r[k][PW-1]}}, lane_r[k]};
        end
    end

    // Counter saturates at MAX_LEN; any further beat flags overflow.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (hs) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (cnt == CNT_W'(MAX_LEN)) ovf <= 1'b1;
            else                        cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_q <= ST_ACCUM;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && in_last)                        state_d = ST_FLUSH;
            ST_FLUSH: if (vld_pipe[STAGES] && last_pipe[STAGES])    state_d = ST_HOLD;
            ST_HOLD:  if (out_ready)                                state_d = ST_ACCUM;
            default:                                                state_d = ST_ACCUM;
        endcase
    end

endmodule

// File: tb/tb_dsp_overpack_mac.sv
// Directed and randomized checks of the over-packed MAC with default geometry.
module tb_dsp_overpack_mac;

    localparam int LANES = 6;
    localparam int ACC_W = 17;
    localparam int W     = LANES * ACC_W;

    logic           CLK = 1'b0;
    logic           RSTN = 1'b0;
    logic [11:0]    in_act = '0;
    logic [7:0]     in_wgt = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_last = 1'b0;
    logic [W-1:0]   out_acc;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_ovf;

    int checks = 0;
    int errors = 0;
    int m[LANES];
    logic [W-1:0] held;

    dsp_overpack_mac dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_acc   (out_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic mclr();
        for (int k = 0; k < LANES; k++) m[k] = 0;
    endtask

    task automatic madd(input logic [11:0] a, input logic [7:0] w);
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 3; i++)
                m[j*3+i] += int'(a[i*4 +: 4]) * int'($signed(w[j*4 +: 4]));
    endtask

    function automatic logic [127:0] mexp();
        logic [127:0] r;
        int t;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            t = m[k];
            r[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [127:0] pk6(input int l0, l1, l2, l3, l4, l5);
        int l[LANES];
        logic [127:0] r;
        int t;
        l = '{l0, l1, l2, l3, l4, l5};
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            t = l[k];
            r[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic beat(input logic [11:0] a, input logic [7:0] w, input logic last, input int gap);
        int n;
        repeat (gap) step();
        in_act = a; in_wgt = w; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'(1));
        step();
        madd(a, w);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 2000) begin step(); n++; end
        if (!out_valid) chk({tag, "_timeout"}, 128'(out_valid), 128'(1));
    endtask

    task automatic wait_res(input string tag, input logic exp_ovf, input bit rnd);
        int n;
        logic hsd;
        wait_vld(tag);
        chk({tag, "_acc"}, 128'(out_acc), mexp());
        chk({tag, "_ovf"}, 128'(out_ovf), 128'(exp_ovf));
        hsd = 1'b0;
        n = 0;
        while (rnd && !hsd && n < 50) begin
            out_ready = 1'($urandom_range(0, 1));
            hsd = out_ready;
            step();
            n++;
        end
        if (!hsd) begin out_ready = 1'b1; step(); end
        out_ready = 1'b0;
        mclr();
    endtask

    initial begin
        mclr();
        step(); step();
        chk("rst_vld", 128'(out_valid), 128'(0));
        chk("rst_acc", 128'(out_acc), 128'(0));
        chk("rst_ovf", 128'(out_ovf), 128'(0));
        chk("rst_rdy", 128'(in_ready), 128'(0));
        RSTN = 1'b1;
        #1;
        chk("rel_rdy", 128'(in_ready), 128'(1));

        // single beat, 4-cycle latency
        beat(12'hFFF, 8'h78, 1'b1, 0);
        step(); step(); step();
        chk("lat3_vld", 128'(out_valid), 128'(0));
        step();
        chk("lat4_vld", 128'(out_valid), 128'(1));
        chk("one_beat", 128'(out_acc), pk6(-120, -120, -120, 105, 105, 105));
        chk("hold_rdy", 128'(in_ready), 128'(0));
        wait_res("one_beat", 1'b0, 1'b0);

        // four beats, then hold off the result while a new vector waits
        for (int b = 0; b < 4; b++) beat(12'h321, 8'hFF, 1'(b == 3), 0);
        wait_vld("four");
        chk("four_const", 128'(out_acc), pk6(-4, -8, -12, -4, -8, -12));
        chk("four_acc", 128'(out_acc), mexp());
        held = out_acc;
        mclr();
        in_act = 12'h205; in_wgt = 8'hE3; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("stall_rdy", 128'(in_ready), 128'(0));
            chk("stall_acc", 128'(out_acc), 128'(held));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_rdy", 128'(in_ready), 128'(1));
        step();
        madd(12'h205, 8'hE3);
        in_valid = 1'b0; in_last = 1'b0;
        wait_vld("second");
        chk("second_const", 128'(out_acc), pk6(15, 0, 6, -10, 0, -4));
        wait_res("second", 1'b0, 1'b0);

        // exactly MAX_LEN beats: no overflow
        for (int b = 0; b < 256; b++) beat(12'hFFF, 8'h88, 1'(b == 255), 0);
        wait_res("len256", 1'b0, 1'b0);

        // MAX_LEN+1 beats: overflow
        for (int b = 0; b < 257; b++) beat(12'hFFF, 8'h88, 1'(b == 256), 0);
        wait_vld("len257");
        chk("len257_const", 128'(out_acc), pk6(-30840, -30840, -30840, -30840, -30840, -30840));
        wait_res("len257", 1'b1, 1'b0);
        chk("ovf_clr", 128'(out_ovf), 128'(0));
        chk("acc_clr", 128'(out_acc), 128'(0));

        // reset during flush discards the vector
        beat(12'h111, 8'h11, 1'b1, 0);
        chk("flush_rdy", 128'(in_ready), 128'(0));
        RSTN = 1'b0;
        #1;
        chk("mid_rst_rdy", 128'(in_ready), 128'(0));
        chk("mid_rst_acc", 128'(out_acc), 128'(0));
        step(); step();
        RSTN = 1'b1;
        #1;
        chk("mid_rel_rdy", 128'(in_ready), 128'(1));
        mclr();
        repeat (6) step();
        chk("no_stale_vld", 128'(out_valid), 128'(0));
        beat(12'h001, 8'h01, 1'b1, 0);
        wait_vld("after_rst");
        chk("after_rst_const", 128'(out_acc), pk6(1, 0, 0, 0, 0, 0));
        wait_res("after_rst", 1'b0, 1'b0);

        // random vectors with bubbles and random back-pressure
        for (int v = 0; v < 1000; v++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                beat(12'($urandom), 8'($urandom), 1'(b == len - 1), $urandom_range(0, 2));
            wait_res("rnd", 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
